// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory address, registered fetch slot with valid/ready to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] HALT_INST  = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Addr,
  input  logic [31:0] Inst,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Inst,
  output logic [31:0] Out_Pc,
  output logic        Halted,
  output logic [1:0]  Fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Perf_Fetched,
  output logic [31:0] Perf_Stall
`endif
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_WORDS * 4 - 4);
  localparam logic [31:0] NOP     = 32'h00000013;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_out_pc;
  logic        r_halted;
  logic [1:0]  r_fault;

  logic w_free;
  logic w_misal;
  logic w_oor;

  assign w_free  = !r_valid || Out_Ready;
  assign w_misal = Redirect_Target[1:0] != 2'b00;
  assign w_oor   = r_pc > LAST_PC;

  assign Addr     = r_pc;
  assign Out_Valid = r_valid;
  assign Out_Inst = r_inst;
  assign Out_Pc   = r_out_pc;
  assign Halted   = r_halted;
  assign Fault    = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_inst   <= NOP;
      r_out_pc <= 32'h0;
      r_halted <= 1'b0;
      r_fault  <= 2'b00;
    end else begin
      case (r_state)
        S_RUN: begin
          if (Redirect_Valid) begin
            // Flush wins even over a same-cycle handshake; decode already took the slot.
            r_valid <= 1'b0;
            if (w_misal) begin
              r_fault  <= 2'b01;
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= Redirect_Target;
            end
          end else if (w_free && w_oor) begin
            r_fault  <= 2'b10;
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_valid  <= 1'b0;
          end else if (w_free) begin
            r_inst   <= Inst;
            r_out_pc <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 32'd4;
            if (Inst == HALT_INST) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (Redirect_Valid) begin
            // The EBREAK in the slot is squashed, so fetch resumes.
            r_valid <= 1'b0;
            if (w_misal) begin
              r_fault  <= 2'b01;
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= Redirect_Target;
              r_state <= S_RUN;
            end
          end else if (r_valid && Out_Ready) begin
            r_valid  <= 1'b0;
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= S_HALT;
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic w_capture;
  logic w_stall;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  assign w_capture = (r_state == S_RUN) && !Redirect_Valid && w_free && !w_oor;
  assign w_stall   = (r_state == S_RUN) && r_valid && !Out_Ready;

  assign Perf_Fetched = r_perf_fetched;
  assign Perf_Stall   = r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
    end else begin
      if (w_capture && r_perf_fetched != 32'hFFFFFFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_stall && r_perf_stall != 32'hFFFFFFFF)     r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: fetch stream, stalls, redirects, faults, EBREAK drain, reset.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_Target = 32'h0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic [31:0] Out_Inst;
  logic [31:0] Out_Pc;
  logic        Halted;
  logic [1:0]  Fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Perf_Fetched;
  logic [31:0] Perf_Stall;
`endif

  logic halt_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .Addr(Addr), .Inst(Inst),
    .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Inst(Out_Inst),
    .Out_Pc(Out_Pc), .Halted(Halted), .Fault(Fault)
`ifdef FETCH_PERF_CNT_EN
    , .Perf_Fetched(Perf_Fetched), .Perf_Stall(Perf_Stall)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: each word encodes its own address so Out_Inst identifies which PC was captured.
  function automatic logic [31:0] mem_f(input logic [31:0] a, input logic he);
    if (he && a == 32'h18) return HALT;
    return {a[24:0], 7'h13};
  endfunction

  always_comb Inst = mem_f(Addr, halt_en);

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_halted;
    logic [1:0]  e_fault;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] tgt, input logic rdy,
                              input logic ev, input logic [31:0] ea, input logic [31:0] ep,
                              input logic eh, input logic [1:0] ef);
    vec_t v;
    v.rv = rv; v.tgt = tgt; v.rdy = rdy;
    v.e_valid = ev; v.e_addr = ea; v.e_pc = ep; v.e_halted = eh; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp, inout bit bad);
    if (act !== exp) begin
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      bad = 1'b1;
    end
  endtask

  task automatic check_outs(input string name, input int idx, input logic ev, input logic [31:0] ea,
                            input logic [31:0] ep, input logic eh, input logic [1:0] ef);
    bit bad = 1'b0;
    chk({name, ".valid"},  idx, {31'b0, Out_Valid}, {31'b0, ev}, bad);
    chk({name, ".addr"},   idx, Addr, ea, bad);
    chk({name, ".pc"},     idx, Out_Pc, ep, bad);
    chk({name, ".inst"},   idx, Out_Inst, mem_f(ep, halt_en), bad);
    chk({name, ".halted"}, idx, {31'b0, Halted}, {31'b0, eh}, bad);
    chk({name, ".fault"},  idx, {30'b0, Fault}, {30'b0, ef}, bad);
    n_vec++;
    if (bad) n_err++;
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      Redirect_Valid  = tbl[i].rv;
      Redirect_Target = tbl[i].tgt;
      Out_Ready       = tbl[i].rdy;
      @(posedge clk);
      #1;
      check_outs(name, i, tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_halted, tbl[i].e_fault);
    end
    Redirect_Valid = 1'b0;
    Out_Ready      = 1'b0;
    tbl.delete();
  endtask

  // Asynchronous reset: outputs must return to reset values before any clock edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    Redirect_Valid = 1'b0;
    Out_Ready = 1'b0;
    #1;
    check_outs(name, 0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_to_halt_slot();
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 0, 1, 1, 32'(4 * i + 4), 32'(4 * i), 0, 2'b00));
  endtask

  initial begin
    do_reset("reset0");

    // Stream, 3-cycle stall, redirects, handshake+redirect, misaligned fault.
    tbl.push_back(mk(0, 0,     1, 1, 32'h04, 32'h00, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h08, 32'h04, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h0C, 32'h08, 0, 2'b00));
    tbl.push_back(mk(0, 0,     0, 1, 32'h0C, 32'h08, 0, 2'b00));
    tbl.push_back(mk(0, 0,     0, 1, 32'h0C, 32'h08, 0, 2'b00));
    tbl.push_back(mk(0, 0,     0, 1, 32'h0C, 32'h08, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h10, 32'h0C, 0, 2'b00));
    tbl.push_back(mk(1, 32'h14, 0, 0, 32'h14, 32'h0C, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h18, 32'h14, 0, 2'b00));
    tbl.push_back(mk(1, 32'h14, 1, 0, 32'h14, 32'h14, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h18, 32'h14, 0, 2'b00));
    tbl.push_back(mk(1, 32'h16, 1, 0, 32'h18, 32'h14, 1, 2'b01));
    tbl.push_back(mk(1, 32'h40, 1, 0, 32'h18, 32'h14, 1, 2'b01));
    tbl.push_back(mk(0, 0,     1, 0, 32'h18, 32'h14, 1, 2'b01));
    run_tbl("stream");

    // EBREAK at 0x18: held in DRAIN under backpressure, then halts after acceptance.
    halt_en = 1'b1;
    do_reset("reset1");
    run_to_halt_slot();
    tbl.push_back(mk(0, 0,     0, 1, 32'h1C, 32'h18, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 0, 32'h1C, 32'h18, 1, 2'b00));
    tbl.push_back(mk(1, 32'h40, 1, 0, 32'h1C, 32'h18, 1, 2'b00));
    run_tbl("drain");

    // Redirect during DRAIN squashes the EBREAK and fetch resumes.
    do_reset("reset2");
    run_to_halt_slot();
    tbl.push_back(mk(1, 32'h40, 0, 0, 32'h40, 32'h18, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h44, 32'h40, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h48, 32'h44, 0, 2'b00));
    run_tbl("drain_redir");
    halt_en = 1'b0;

    // Walk off the end of a 32-word memory: 0x7C is the last legal fetch.
    do_reset("reset3");
    tbl.push_back(mk(1, 32'h78, 1, 0, 32'h78, 32'h00, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h7C, 32'h78, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 1, 32'h80, 32'h7C, 0, 2'b00));
    tbl.push_back(mk(0, 0,     1, 0, 32'h80, 32'h7C, 1, 2'b10));
    tbl.push_back(mk(0, 0,     1, 0, 32'h80, 32'h7C, 1, 2'b10));
    run_tbl("range");

    // Fault must clear on reset; then reset again in the middle of a stall.
    do_reset("reset4");
    tbl.push_back(mk(0, 0, 1, 1, 32'h04, 32'h00, 0, 2'b00));
    tbl.push_back(mk(0, 0, 1, 1, 32'h08, 32'h04, 0, 2'b00));
    tbl.push_back(mk(0, 0, 0, 1, 32'h08, 32'h04, 0, 2'b00));
    run_tbl("stall");
    do_reset("reset_midstall");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the single-cycle/pipelined RISC-V core; sits directly upstream of the combinational instruction memory and drives its word address.
- Holds the program counter, presents `Addr` to instruction memory, captures the returned `Inst` into a registered fetch slot, and hands it to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/JALR targets) from execute and halts on a fault or on EBREAK.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_WORDS, 32, instruction memory depth in words; the legal fetch range is 0 .. IMEM_WORDS*4-4.
- HALT_INST, 32'h00100073, encoding (EBREAK) that halts fetch after it is delivered.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Addr  output  32  byte address to instruction memory; equals PC combinationally.
- Inst  input  32  instruction word from memory, valid in the same cycle as Addr.
- Redirect_Valid  input  1  execute requests a PC change this cycle.
- Redirect_Target  input  32  new PC when Redirect_Valid=1.
- Out_Valid  output  1  fetch slot holds an instruction for decode.
- Out_Ready  input  1  decode accepts the slot this cycle.
- Out_Inst  output  32  registered instruction.
- Out_Pc  output  32  PC of Out_Inst.
- Halted  output  1  fetch stopped (HALT state).
- Fault  output  2  00 none, 01 misaligned target, 10 PC out of range; sticky until reset.

Behaviour:
- Reset (async, any state):
  - PC=RESET_PC, state=RUN, Out_Valid=0, Out_Inst=32'h00000013, Out_Pc=0, Halted=0, Fault=00.
  - Reset asserted mid-operation discards the slot immediately.
- Fetch slot is free when Out_Valid=0 or Out_Ready=1.
- RUN, priority highest first:
  1. Redirect_Valid=1:
     - Out_Valid<=0 (flush; the slot is dropped even if Out_Ready=1 is not the handshake cycle).
     - If Redirect_Target[1:0]!=0: Fault<=01, state<=HALT, PC unchanged.
     - Otherwise PC<=Redirect_Target. No capture this cycle.
  2. Slot free and PC > IMEM_WORDS*4-4: Fault<=10, state<=HALT, Out_Valid<=0.
  3. Slot free:
     - Out_Inst<=Inst, Out_Pc<=PC, Out_Valid<=1, PC<=PC+4 (32-bit wrap, no carry out).
     - If Inst==HALT_INST: state<=DRAIN.
  4. Slot not free (Out_Valid=1, Out_Ready=0): stall; PC, Out_* held unchanged.
- DRAIN:
  - No new fetches; PC held.
  - When Out_Ready=1 with Out_Valid=1: Out_Valid<=0, state<=HALT.
  - Redirect_Valid=1 in DRAIN: handled as in RUN (flush), and state<=RUN (the halt instruction was squashed).
- HALT:
  - Halted=1 (registered, asserted the cycle after entry).
  - Out_Valid=0; all inputs ignored until reset.
- Latency: address to Out_Valid is 1 cycle; steady throughput is 1 instruction per cycle with Out_Ready=1.
- Redirect and handshake in the same cycle: the handshake completes for the current slot (decode consumed it), the redirect still flushes the next fetch, and Out_Valid<=0.
- Out_* never change while Out_Valid=1 and Out_Ready=0, except on redirect or reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs Perf_Fetched (32) and Perf_Stall (32), both reset to 0.
  - Perf_Fetched increments on each slot capture.
  - Perf_Stall increments on each RUN cycle with Out_Valid=1 and Out_Ready=0.
  - Both saturate at 32'hFFFFFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then Out_Ready=1 and memory returns 32'h00000013 everywhere -> Addr sequence 0,4,8,12; Out_Pc lags Addr by 1 cycle; Out_Valid=1 from cycle 1.
- Hold Out_Ready=0 for 3 cycles at Out_Pc=8 -> Out_Inst/Out_Pc stable, Addr stays 12; the release delivers PC 12 next.
- Redirect_Valid=1, Target=32'h00000014 while slot valid -> next cycle Out_Valid=0, Addr=0x14; the following cycle Out_Pc=0x14.
- Redirect_Target=32'h00000016 -> Fault=01, Halted=1 one cycle later; Addr frozen; further redirects ignored.
- Memory returns 32'h00100073 at PC 0x18 -> delivered with Out_Pc=0x18; after acceptance Halted=1 and no fetch of 0x1C. Repeat with a redirect during DRAIN -> resumes at the target, Halted=0.
- Sequential run to PC=0x80 (IMEM_WORDS=32) -> Fault=10, Halted=1, no slot with Out_Pc=0x80. Assert rst mid-stall -> all outputs at reset values immediately.
